rv_lsu: RTL and testbench

RV_LSU -- requirements
Module: rv_lsu

---
 rtl/rv_lsu.sv | 200 ++++++++++++++++++++
 tb/tb_rv_lsu.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_lsu.sv
// rv_lsu: load/store unit pipeline stage for a 32-bit RISC-V core.
//
// Captures the execute-stage op into a stage register. The register holds while the stage
// stalls. Aligned loads and stores are issued on a simple req/ack bus. Write-back and bypass
// values are presented from the captured op.
//
// Ports
//   i_clk, i_reset_n        rising-edge clock, asynchronous active-low reset
//   i_flush                 replace the incoming op with a bubble (recorded if stalled)
//   i_alu_result .. i_rs2_val  execute-stage op (address/ALU value, control, store data)
//   o_bus_*                 request side of the memory bus (valid only in the REQ state)
//   i_bus_ack, i_bus_rdata  bus completion and read data
//   o_stall                 hold upstream stages while a bus transaction is outstanding
//   o_misalign              one-cycle fault pulse for a misaligned load/store
//   o_reg_write .. o_pc_p4  write-back / bypass view of the captured op
module rv_lsu (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_flush,
    input  logic [31:0] i_alu_result,
    input  logic        i_reg_write,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [4:0]  i_rd,
    input  logic [29:0] i_pc_p4,
    input  logic [1:0]  i_res_src,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs2_val,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_stall,
    output logic        o_misalign,
    output logic        o_reg_write,
    output logic [4:0]  o_rd,
    output logic [31:0] o_rd_val,
    output logic [1:0]  o_res_src,
    output logic [29:0] o_pc_p4
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  rd;
        logic [1:0]  res_src;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [29:0] pc_p4;
    } stage_t;

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b001, 3'b101: is_misaligned = a[0];
            3'b010:         is_misaligned = (a != 2'b00);
            default:        is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [15:0] half;
        shifted = rdata >> {a, 3'b000};
        half    = a[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  extract_load = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  extract_load = {{16{half[15]}}, half};
            3'b010:  extract_load = rdata;
            3'b100:  extract_load = {24'd0, shifted[7:0]};
            3'b101:  extract_load = {16'd0, half};
            default: extract_load = 32'd0;
        endcase
    endfunction

    state_e      state_q, state_d;
    stage_t      stage_q, stage_d;
    logic [31:0] load_q, load_d;
    logic        flush_q, flush_d;
    logic        stall;
    logic        bus_req;
    logic        capture_mem;
    logic        misalign;

    // An incoming op that will actually go to the bus if captured on this edge.
    assign capture_mem = !i_flush && (i_mem_read || i_mem_write) &&
                         !is_misaligned(i_funct3, i_alu_result[1:0]);

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
            stage_q <= '0;
            load_q  <= 32'd0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            load_q  <= load_d;
            flush_q <= flush_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (capture_mem) state_d = StReq;
            StReq:   if (i_bus_ack) state_d = StResp;
            StResp:  state_d = capture_mem ? StReq : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus_req = 1'b0;
        stall   = 1'b0;
        if (state_q == StReq) begin
            bus_req = 1'b1;
            stall   = 1'b1;
        end
    end

    // Stage register, load data and recorded flush
    always_comb begin
        stage_d = stage_q;
        if (!stall) begin
            if (i_flush) begin
                stage_d = '0;
            end else begin
                stage_d = '{reg_write: i_reg_write, mem_read: i_mem_read,
                            mem_write: i_mem_write, rd: i_rd, res_src: i_res_src,
                            funct3: i_funct3, addr: i_alu_result, rs2: i_rs2_val,
                            pc_p4: i_pc_p4};
            end
        end

        load_d = load_q;
        if (bus_req && i_bus_ack) begin
            load_d = extract_load(stage_q.funct3, stage_q.addr[1:0], i_bus_rdata);
        end

        // A flush seen while stalled cannot bubble the held op; it suppresses its write-back.
        flush_d = stall ? (flush_q | i_flush) : 1'b0;
    end

    assign misalign = (stage_q.mem_read || stage_q.mem_write) &&
                      is_misaligned(stage_q.funct3, stage_q.addr[1:0]);

    always_comb begin
        o_bus_req   = bus_req;
        o_bus_we    = 1'b0;
        o_bus_addr  = 32'd0;
        o_bus_be    = 4'd0;
        o_bus_wdata = 32'd0;
        if (bus_req) begin
            o_bus_we   = stage_q.mem_write;
            o_bus_addr = {stage_q.addr[31:2], 2'b00};
            o_bus_be   = 4'b1111;
            o_bus_wdata = stage_q.rs2;
            if (stage_q.mem_write) begin
                case (stage_q.funct3[1:0])
                    2'b00: begin
                        o_bus_be    = 4'b0001 << stage_q.addr[1:0];
                        o_bus_wdata = {4{stage_q.rs2[7:0]}};
                    end
                    2'b01: begin
                        o_bus_be    = 4'b0011 << stage_q.addr[1:0];
                        o_bus_wdata = {2{stage_q.rs2[15:0]}};
                    end
                    default: ;
                endcase
            end
        end

        o_stall     = stall;
        o_misalign  = misalign && !stall;
        o_reg_write = !stall && stage_q.reg_write && !flush_q && !misalign;
        o_rd        = stage_q.rd;
        o_res_src   = stage_q.res_src;
        o_pc_p4     = stage_q.pc_p4;

        case (stage_q.res_src)
            2'b00:   o_rd_val = stage_q.addr;
            2'b01:   o_rd_val = load_q;
            2'b10:   o_rd_val = {stage_q.pc_p4, 2'b00};
            default: o_rd_val = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_rv_lsu.sv
module tb_rv_lsu;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_flush;
    logic [31:0] i_alu_result;
    logic        i_reg_write;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [4:0]  i_rd;
    logic [29:0] i_pc_p4;
    logic [1:0]  i_res_src;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs2_val;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
    logic        o_stall;
    logic        o_misalign;
    logic        o_reg_write;
    logic [4:0]  o_rd;
    logic [31:0] o_rd_val;
    logic [1:0]  o_res_src;
    logic [29:0] o_pc_p4;

    int checks = 0;
    int errors = 0;

    rv_lsu dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_flush      (i_flush),
        .i_alu_result (i_alu_result),
        .i_reg_write  (i_reg_write),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_rd         (i_rd),
        .i_pc_p4      (i_pc_p4),
        .i_res_src    (i_res_src),
        .i_funct3     (i_funct3),
        .i_rs2_val    (i_rs2_val),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_be     (o_bus_be),
        .o_bus_wdata  (o_bus_wdata),
        .i_bus_ack    (i_bus_ack),
        .i_bus_rdata  (i_bus_rdata),
        .o_stall      (o_stall),
        .o_misalign   (o_misalign),
        .o_reg_write  (o_reg_write),
        .o_rd         (o_rd),
        .o_rd_val     (o_rd_val),
        .o_res_src    (o_res_src),
        .o_pc_p4      (o_pc_p4)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic rw, input logic mr, input logic mw, input logic [4:0] rd,
                            input logic [1:0] rs, input logic [2:0] f3, input logic [31:0] alu,
                            input logic [31:0] rs2, input logic [29:0] pc);
        i_flush      = 1'b0;
        i_reg_write  = rw;
        i_mem_read   = mr;
        i_mem_write  = mw;
        i_rd         = rd;
        i_res_src    = rs;
        i_funct3     = f3;
        i_alu_result = alu;
        i_rs2_val    = rs2;
        i_pc_p4      = pc;
    endtask

    task automatic bubble();
        drive_op(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'd0, 32'd0, 30'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 32'(o_bus_req), 32'd0);
        check({tag, "_we"}, 32'(o_bus_we), 32'd0);
        check({tag, "_addr"}, o_bus_addr, 32'd0);
        check({tag, "_be"}, 32'(o_bus_be), 32'd0);
        check({tag, "_wdata"}, o_bus_wdata, 32'd0);
        check({tag, "_stall"}, 32'(o_stall), 32'd0);
        check({tag, "_mis"}, 32'(o_misalign), 32'd0);
        check({tag, "_rw"}, 32'(o_reg_write), 32'd0);
        check({tag, "_rd"}, 32'(o_rd), 32'd0);
        check({tag, "_rdval"}, o_rd_val, 32'd0);
        check({tag, "_ressrc"}, 32'(o_res_src), 32'd0);
        check({tag, "_pc"}, 32'(o_pc_p4), 32'd0);
    endtask

    // Load with ack in the first REQ cycle; checks the single stall cycle and the result.
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        drive_op(1'b1, 1'b1, 1'b0, 5'd9, 2'b01, f3, addr, 32'd0, 30'd0);
        @(negedge i_clk);
        check({tag, "_req"}, 32'(o_bus_req), 32'd1);
        check({tag, "_stall"}, 32'(o_stall), 32'd1);
        check({tag, "_rw_stall"}, 32'(o_reg_write), 32'd0);
        check({tag, "_be"}, 32'(o_bus_be), 32'hF);
        check({tag, "_addr"}, o_bus_addr, {addr[31:2], 2'b00});
        i_bus_ack   = 1'b1;
        i_bus_rdata = rdata;
        bubble();
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        check({tag, "_stall_done"}, 32'(o_stall), 32'd0);
        check({tag, "_rw"}, 32'(o_reg_write), 32'd1);
        check({tag, "_val"}, o_rd_val, exp);
        check({tag, "_rd"}, 32'(o_rd), 32'd9);
    endtask

    initial begin
        i_reset_n   = 1'b0;
        i_bus_ack   = 1'b0;
        i_bus_rdata = 32'd0;
        bubble();

        // Reset state
        @(negedge i_clk);
        check_all_zero("reset");
        i_reset_n = 1'b1;

        // LW 0x100, ack in first REQ cycle
        run_load("lw", 3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
        @(negedge i_clk);
        check("lw_idle_rw", 32'(o_reg_write), 32'd0);
        check("lw_idle_req", 32'(o_bus_req), 32'd0);

        // Byte / halfword extraction
        run_load("lb", 3'b000, 32'h103, 32'h80112233, 32'hFFFFFF80);
        run_load("lbu", 3'b100, 32'h103, 32'h80112233, 32'h00000080);
        run_load("lh", 3'b001, 32'h102, 32'h80112233, 32'hFFFF8011);
        run_load("lhu", 3'b101, 32'h102, 32'h80112233, 32'h00008011);
        run_load("lb1", 3'b000, 32'h101, 32'h80112233, 32'h00000022);

        // SH 0x202, ack after 3 stall cycles, bus fields held stable
        drive_op(1'b0, 1'b0, 1'b1, 5'd0, 2'b00, 3'b001, 32'h202, 32'h0000ABCD, 30'd0);
        @(negedge i_clk);
        bubble();
        for (int i = 0; i < 3; i++) begin
            check("sh_stall", 32'(o_stall), 32'd1);
            check("sh_req", 32'(o_bus_req), 32'd1);
            check("sh_we", 32'(o_bus_we), 32'd1);
            check("sh_addr", o_bus_addr, 32'h200);
            check("sh_be", 32'(o_bus_be), 32'hC);
            check("sh_wdata", o_bus_wdata, 32'hABCDABCD);
            if (i == 2) i_bus_ack = 1'b1;
            @(negedge i_clk);
        end
        i_bus_ack = 1'b0;
        check("sh_done_stall", 32'(o_stall), 32'd0);
        check("sh_done_req", 32'(o_bus_req), 32'd0);
        check("sh_done_rw", 32'(o_reg_write), 32'd0);

        // SB 0x101
        drive_op(1'b0, 1'b0, 1'b1, 5'd0, 2'b00, 3'b000, 32'h101, 32'h12345678, 30'd0);
        @(negedge i_clk);
        check("sb_be", 32'(o_bus_be), 32'h2);
        check("sb_wdata", o_bus_wdata, 32'h78787878);
        check("sb_addr", o_bus_addr, 32'h100);
        i_bus_ack = 1'b1;
        bubble();
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        check("sb_done_stall", 32'(o_stall), 32'd0);

        // Misaligned LW 0x101
        drive_op(1'b1, 1'b1, 1'b0, 5'd6, 2'b01, 3'b010, 32'h101, 32'd0, 30'd0);
        @(negedge i_clk);
        check("mis_req", 32'(o_bus_req), 32'd0);
        check("mis_pulse", 32'(o_misalign), 32'd1);
        check("mis_rw", 32'(o_reg_write), 32'd0);
        check("mis_stall", 32'(o_stall), 32'd0);
        bubble();
        @(negedge i_clk);
        check("mis_end", 32'(o_misalign), 32'd0);
        check("mis_end_req", 32'(o_bus_req), 32'd0);

        // Misaligned SH 0x203
        drive_op(1'b0, 1'b0, 1'b1, 5'd0, 2'b00, 3'b001, 32'h203, 32'h1, 30'd0);
        @(negedge i_clk);
        check("mis_sh_pulse", 32'(o_misalign), 32'd1);
        check("mis_sh_req", 32'(o_bus_req), 32'd0);
        bubble();

        // ALU result and PC+4 selections
        drive_op(1'b1, 1'b0, 1'b0, 5'd3, 2'b00, 3'b000, 32'h12345678, 32'd0, 30'd0);
        @(negedge i_clk);
        check("alu_val", o_rd_val, 32'h12345678);
        check("alu_rw", 32'(o_reg_write), 32'd1);
        check("alu_rd", 32'(o_rd), 32'd3);
        drive_op(1'b1, 1'b0, 1'b0, 5'd1, 2'b10, 3'b000, 32'h5, 32'd0, 30'h40);
        @(negedge i_clk);
        check("pc_val", o_rd_val, 32'h100);
        check("pc_pc", 32'(o_pc_p4), 32'h40);
        check("pc_ressrc", 32'(o_res_src), 32'd2);
        drive_op(1'b1, 1'b0, 1'b0, 5'd2, 2'b11, 3'b000, 32'h5, 32'd0, 30'h40);
        @(negedge i_clk);
        check("rs11_val", o_rd_val, 32'd0);

        // Flush at capture yields a bubble
        drive_op(1'b1, 1'b0, 1'b0, 5'd3, 2'b00, 3'b000, 32'h12345678, 32'd0, 30'd0);
        i_flush = 1'b1;
        @(negedge i_clk);
        check("flush_rw", 32'(o_reg_write), 32'd0);
        check("flush_rd", 32'(o_rd), 32'd0);

        // Back-to-back LW/SW, flush during first REQ, reset during second REQ
        drive_op(1'b1, 1'b1, 1'b0, 5'd7, 2'b01, 3'b010, 32'h100, 32'd0, 30'd0);
        @(negedge i_clk);
        check("b2b_req1", 32'(o_bus_req), 32'd1);
        drive_op(1'b0, 1'b0, 1'b1, 5'd0, 2'b00, 3'b010, 32'h204, 32'h11223344, 30'd0);
        i_flush     = 1'b1;
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'h55555555;
        @(negedge i_clk);
        i_flush   = 1'b0;
        i_bus_ack = 1'b0;
        check("b2b_resp_rw", 32'(o_reg_write), 32'd0);
        check("b2b_resp_rd", 32'(o_rd), 32'd7);
        check("b2b_resp_stall", 32'(o_stall), 32'd0);
        @(negedge i_clk);
        check("b2b_req2", 32'(o_bus_req), 32'd1);
        check("b2b_we2", 32'(o_bus_we), 32'd1);
        check("b2b_addr2", o_bus_addr, 32'h204);
        check("b2b_wdata2", o_bus_wdata, 32'h11223344);
        #2;
        i_reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        bubble();
        @(negedge i_clk);
        check_all_zero("held_rst");

        // First capture happens on the first edge after reset release
        drive_op(1'b1, 1'b0, 1'b0, 5'd4, 2'b00, 3'b000, 32'hCAFE0001, 32'd0, 30'd0);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        check("post_rst_rw", 32'(o_reg_write), 32'd1);
        check("post_rst_val", o_rd_val, 32'hCAFE0001);
        check("post_rst_rd", 32'(o_rd), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
